// File: rtl/multi_sel_seq.sv
// multi_sel_seq: captures a sample and emits its product with each of NSTEP
// coefficients on consecutive cycles, one product per cycle.
// Define MULTI_SEL_SEQ_SAT_EN to saturate products wider than OW bits;
// without it the products wrap modulo 2^OW.
module multi_sel_seq #(
  parameter int DW = 8,
  parameter int CW = 4,
  parameter int NSTEP = 4,
  parameter logic [NSTEP*CW-1:0] COEFS = {4'd8, 4'd7, 4'd3, 4'd1},
  parameter int OW = DW + CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] d,
  output logic          input_grant,
  output logic          out_valid,
  output logic [OW-1:0] out,
  output logic [2:0]    step,
  output logic          last
);
  localparam int PW = DW + CW;
  localparam logic IDLE = 1'b0;
  localparam logic RUN = 1'b1;
  localparam logic [2:0] LAST = 3'(NSTEP - 1);
  logic          r_state;
  logic [2:0]    r_cnt;
  logic [DW-1:0] r_d;
  logic [OW-1:0] r_out;
  logic          r_valid;
  logic          w_cap;
  logic [2:0]    w_idx;
  logic [DW-1:0] w_src;
  logic [CW-1:0] w_coef;
  logic [PW-1:0] w_prod;
  logic [OW-1:0] w_out;
  assign input_grant = (r_state == IDLE) || (r_cnt == LAST);
  assign w_cap = in_valid && input_grant;
  assign w_idx = w_cap ? 3'd0 : r_cnt + 3'd1;
  assign w_src = w_cap ? d : r_d;
  assign out_valid = r_valid;
  assign out = r_out;
  assign step = r_cnt;
  assign last = r_valid && (r_cnt == LAST);
  // Pick the coefficient for the upcoming step and form the exact product by shift-and-add.
  always_comb begin
    w_coef = '0;
    for (int k = 0; k < NSTEP; k++)
      if (w_idx == 3'(k)) w_coef = COEFS[k*CW +: CW];
    w_prod = '0;
    for (int i = 0; i < CW; i++)
      if (w_coef[i]) w_prod = w_prod + (PW'(w_src) << i);
  end
`ifdef MULTI_SEL_SEQ_SAT_EN
  assign w_out = |(w_prod >> OW) ? '1 : w_prod[OW-1:0];
`else
  assign w_out = w_prod[OW-1:0];
`endif
  // Sequencer: capture starts a sample, RUN walks the steps, the last step hands back to IDLE or recaptures.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt <= 3'd0;
      r_d <= '0;
      r_out <= '0;
      r_valid <= 1'b0;
    end else if (w_cap) begin
      r_state <= RUN;
      r_cnt <= 3'd0;
      r_d <= d;
      r_out <= w_out;
      r_valid <= 1'b1;
    end else if (r_state == RUN && r_cnt != LAST) begin
      r_cnt <= r_cnt + 3'd1;
      r_out <= w_out;
    end else if (r_state == RUN) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
    end
  end
endmodule

// File: doc/multi_sel_seq.md
MULTI_SEL_SEQ -- requirements
Module: multi_sel_seq

Interface
REQ-001 Parameter DW, default 8: input data width, range 2..16.
REQ-002 Parameter CW, default 4: coefficient width, range 1..8.
REQ-003 Parameter NSTEP, default 4: products per captured sample, range 2..8.
REQ-004 Parameter COEFS, default {4'd8,4'd7,4'd3,4'd1}: NSTEP*CW packed unsigned coefficients; step k is slice [k*CW +: CW].
REQ-005 Parameter OW, default DW+CW: output width, range DW..DW+CW.
REQ-006 clk  input  1  clock; all state updates on the rising edge.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 in_valid  input  1  d carries a sample this cycle.
REQ-009 d  input  DW  unsigned sample.
REQ-010 input_grant  output  1  block accepts d this cycle.
REQ-011 out_valid  output  1  out/step/last are valid.
REQ-012 out  output  OW  product d*COEF[step].
REQ-013 step  output  3  index of the coefficient applied to out.
REQ-014 last  output  1  high with out_valid when step==NSTEP-1.

Function
REQ-015 The FSM SHALL have two states: IDLE and RUN (step counter cnt, 0..NSTEP-1).
REQ-016 input_grant SHALL be 1 in IDLE or in RUN with cnt==NSTEP-1, else 0; it SHALL be decoded from registers only, with no path from in_valid or d.
REQ-017 A capture SHALL occur on a rising edge with in_valid && input_grant; d is latched to d_reg.
REQ-018 On capture: out <= d*COEF[0], step <= 0, out_valid <= 1, state <= RUN; latency is 1 cycle.
REQ-019 In RUN with cnt<NSTEP-1: out <= d_reg*COEF[cnt+1], step <= cnt+1, out_valid stays 1; in_valid is ignored.
REQ-020 In RUN with cnt==NSTEP-1 and no capture: out_valid <= 0 and state <= IDLE; out and step SHALL hold their last values.
REQ-021 A capture in the last step SHALL start the next sample with no bubble, giving a sustained rate of one sample per NSTEP cycles.
REQ-022 Products SHALL be formed by shift-and-add over the CW coefficient bits, with no multiplier operator, and SHALL be exact before output-width handling.
REQ-023 A zero coefficient SHALL produce out=0 with out_valid=1.
REQ-024 Output-width handling SHALL follow REQ-029/REQ-030 when OW<DW+CW; when OW==DW+CW the product is always exact.

Reset
REQ-025 On rst low: state IDLE, cnt=0, d_reg=0, out=0, step=0, out_valid=0; input_grant SHALL read 1.
REQ-026 Reset asserted mid-sequence SHALL abort the sequence immediately, and the remaining steps SHALL never be emitted.
REQ-027 The first capture SHALL be possible on the first rising edge after rst deasserts.

Configuration
REQ-028 The macro MULTI_SEL_SEQ_SAT_EN SHALL select the overflow behaviour.
REQ-029 With MULTI_SEL_SEQ_SAT_EN defined, a product > 2^OW-1 SHALL output all ones.
REQ-030 Without MULTI_SEL_SEQ_SAT_EN, out SHALL be the low OW bits of the product (modulo 2^OW).

Verification
REQ-031 Defaults, d=255 with in_valid for one cycle -> out 255, 765, 1785, 2040 on four consecutive cycles; step 0..3; last only on step 3; then out_valid=0.
REQ-032 Defaults, in_valid held high with d=1 then d=2 -> out 1, 3, 7, 8, 2, 6, 14, 16 with no gap; input_grant high only in the cycles with step 3.
REQ-033 in_valid pulsed while step=1 -> the pulse is ignored, d_reg is unchanged, and no extra outputs appear.
REQ-034 rst pulsed low while step=2 -> out=0 and out_valid=0 immediately; the next capture restarts at step 0.
REQ-035 OW=10, d=200 -> with macro: 200, 600, 1023, 1023; without macro: 200, 600, 376, 576.
REQ-036 COEFS={4'd0,4'd15,4'd2,4'd0}, d=255 -> out 0, 510, 3825, 0 with out_valid high on all four cycles.
